ascon_fsm: RTL and testbench

- Sequencing controller for the Ascon-128 permutation datapath. The datapath has an upstream 64-bit XOR on x0, a downstream 256-bit XOR on x1..x4, an input mux and a state register with write enable.
- It runs one round per clock through four phases: initialisation, associated data (AD), plaintext blocks and finalisation.
- It drives round index, mux/XOR selects and register enable, and handshakes data blocks with the testbench or top level.
- It sits beside the permutation datapath inside the Ascon top; outputs connect 1:1 to the datapath control inputs.

---
 rtl/ascon_fsm_pkg.sv | 29 ++
 rtl/ascon_fsm_if.sv | 28 ++
 rtl/ascon_fsm_round_counter.sv | 25 ++
 rtl/ascon_fsm.sv | 104 ++++++++++
 tb/tb_ascon_fsm.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ascon_fsm_pkg.sv
// Shared constants for the Ascon-128 sequencing controller: state codes,
// downstream XOR select codes and round bounds.
package ascon_fsm_pkg;

    typedef logic [2:0] type_fsm_state;

    localparam type_fsm_state ST_IDLE    = 3'd0;
    localparam type_fsm_state ST_INIT    = 3'd1;
    localparam type_fsm_state ST_WAIT_AD = 3'd2;
    localparam type_fsm_state ST_AD      = 3'd3;
    localparam type_fsm_state ST_WAIT_PT = 3'd4;
    localparam type_fsm_state ST_PT      = 3'd5;
    localparam type_fsm_state ST_FINAL   = 3'd6;
    localparam type_fsm_state ST_DONE    = 3'd7;

    localparam logic [1:0] XDN_NONE   = 2'b00;
    localparam logic [1:0] XDN_KEY_LO = 2'b01;
    localparam logic [1:0] XDN_DOMSEP = 2'b10;
    localparam logic [1:0] XDN_KEY_HI = 2'b11;

    localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
    localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    function automatic logic is_round_state(input type_fsm_state s);
        return (s == ST_INIT) || (s == ST_AD) || (s == ST_PT) || (s == ST_FINAL);
    endfunction

endpackage

// File: rtl/ascon_fsm_if.sv
// Control/handshake bundle between the controller and the Ascon datapath/top.
interface ascon_fsm_if;
    logic       start_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       input_select_o;
    logic       xorup_select_o;
    logic [1:0] xordn_select_o;
    logic       ena_reg_o;
    logic [3:0] block_index_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, data_valid_i,
        input  data_ready_o, round_o, input_select_o, xorup_select_o, xordn_select_o,
               ena_reg_o, block_index_o, cipher_valid_o, tag_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, data_valid_i,
        output data_ready_o, round_o, input_select_o, xorup_select_o, xordn_select_o,
               ena_reg_o, block_index_o, cipher_valid_o, tag_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_fsm_round_counter.sv
// 4-bit round index: loads the first round of a p12 or p6 phase, then steps.
module ascon_fsm_round_counter
    import ascon_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       load_p6,
    input  logic       inc,
    output logic [3:0] round,
    output logic       last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            round <= ROUND_P12_FIRST;
        else if (load)
            round <= load_p6 ? ROUND_P6_FIRST : ROUND_P12_FIRST;
        else if (inc)
            round <= round + 4'd1;
    end

    assign last = (round == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// Ascon-128 round sequencer: one permutation round per clock across INIT, AD,
// PT and FINAL phases. Outputs decode only registered state, never inputs.
module ascon_fsm
    import ascon_fsm_pkg::*;
#(
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    ascon_fsm_if.slave  bus
);

    localparam logic [3:0] LAST_BLK = 4'(NB_PT_BLOCKS - 1);
    localparam logic [3:0] KEY_BLK  = 4'(NB_PT_BLOCKS - 2);

    type_fsm_state state, next_state;
    logic [3:0]    round, blk;
    logic          last, load, load_p6, inc, start_ok;

    ascon_fsm_round_counter u_round_counter (
        .clk     (clock_i),
        .rst_n   (resetb_i),
        .load    (load),
        .load_p6 (load_p6),
        .inc     (inc),
        .round   (round),
        .last    (last)
    );

    assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start_i;
    assign inc      = is_round_state(state) && !last;

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_p6    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start_i) begin
                next_state = ST_INIT;
                load       = 1'b1;
            end
            ST_INIT:  if (last) next_state = ST_WAIT_AD;
            ST_WAIT_AD: if (bus.data_valid_i) begin
                next_state = ST_AD;
                load       = 1'b1;
                load_p6    = 1'b1;
            end
            ST_AD:    if (last) next_state = ST_WAIT_PT;
            // The last PT block is absorbed by the first FINAL round, not a PT phase.
            ST_WAIT_PT: if (bus.data_valid_i) begin
                load = 1'b1;
                if (blk == LAST_BLK) begin
                    next_state = ST_FINAL;
                end else begin
                    next_state = ST_PT;
                    load_p6    = 1'b1;
                end
            end
            ST_PT:    if (last) next_state = ST_WAIT_PT;
            ST_FINAL: if (last) next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= ST_IDLE;
            blk   <= 4'd0;
        end else begin
            state <= next_state;
            if (start_ok)
                blk <= 4'd0;
            else if ((state == ST_PT) && last)
                blk <= blk + 4'd1;
        end
    end

    always_comb begin
        bus.xordn_select_o = XDN_NONE;
        if (last) begin
            case (state)
                ST_INIT, ST_FINAL: bus.xordn_select_o = XDN_KEY_LO;
                ST_AD:             bus.xordn_select_o = XDN_DOMSEP;
                // Finalisation key is pre-applied at the end of the penultimate block.
                ST_PT:             bus.xordn_select_o = (blk == KEY_BLK) ? XDN_KEY_HI : XDN_NONE;
                default:           bus.xordn_select_o = XDN_NONE;
            endcase
        end
    end

    assign bus.round_o        = round;
    assign bus.block_index_o  = blk;
    assign bus.ena_reg_o      = is_round_state(state);
    assign bus.input_select_o = is_round_state(state) && !((state == ST_INIT) && (round == ROUND_P12_FIRST));
    assign bus.xorup_select_o = (((state == ST_AD) || (state == ST_PT)) && (round == ROUND_P6_FIRST))
                             || ((state == ST_FINAL) && (round == ROUND_P12_FIRST));
    assign bus.cipher_valid_o = ((state == ST_PT) && (round == ROUND_P6_FIRST))
                             || ((state == ST_FINAL) && (round == ROUND_P12_FIRST));
    assign bus.tag_valid_o    = (state == ST_FINAL) && last;
    assign bus.data_ready_o   = (state == ST_WAIT_AD) || (state == ST_WAIT_PT);
    assign bus.busy_o         = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.done_o         = (state == ST_DONE);

endmodule

// File: tb/tb_ascon_fsm.sv
// Random start/data_valid stimulus against a phase-schedule model of the controller.
module tb_ascon_fsm;

    localparam int NB = 4;
    localparam int K_INIT = 0, K_AD = 1, K_PT = 2, K_FIN = 3;
    localparam int M_IDLE = 0, M_WAIT_AD = 1, M_WAIT_PT = 2, M_DONE = 3;

    typedef struct packed {
        logic       ready;
        logic [3:0] rnd;
        logic       insel;
        logic       xup;
        logic [1:0] xdn;
        logic       ena;
        logic [3:0] bi;
        logic       cv;
        logic       tv;
        logic       busy;
        logic       done;
    } rec_t;

    logic clock_i = 1'b0;
    logic resetb_i = 1'b0;
    ascon_fsm_if io();

    ascon_fsm #(.NB_PT_BLOCKS(NB)) dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .bus      (io)
    );

    always #5 clock_i = ~clock_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_tags   = 0;
    rec_t q[$];
    rec_t cur;
    int   mode;
    int   blk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return {14'd0, io.data_ready_o, io.round_o, io.input_select_o, io.xorup_select_o,
                io.xordn_select_o, io.ena_reg_o, io.block_index_o, io.cipher_valid_o,
                io.tag_valid_o, io.busy_o, io.done_o};
    endfunction

    function automatic rec_t wait_rec(input int m, input int b);
        rec_t x = '0;
        x.rnd   = (m == M_IDLE) ? 4'd0 : 4'd11;
        x.bi    = 4'(b);
        x.ready = (m == M_WAIT_AD) || (m == M_WAIT_PT);
        x.busy  = x.ready;
        x.done  = (m == M_DONE);
        return x;
    endfunction

    task automatic push_phase(input int kind, input int b);
        int first = (kind == K_INIT || kind == K_FIN) ? 0 : 6;
        for (int r = first; r <= 11; r++) begin
            rec_t x = '0;
            x.ena   = 1'b1;
            x.busy  = 1'b1;
            x.rnd   = 4'(r);
            x.bi    = 4'(b);
            x.insel = !(kind == K_INIT && r == 0);
            x.xup   = (r == first) && (kind != K_INIT);
            x.cv    = (r == first) && (kind == K_PT || kind == K_FIN);
            x.tv    = (r == 11) && (kind == K_FIN);
            if (r == 11) begin
                case (kind)
                    K_INIT, K_FIN: x.xdn = 2'b01;
                    K_AD:          x.xdn = 2'b10;
                    default:       x.xdn = (b == NB - 2) ? 2'b11 : 2'b00;
                endcase
            end
            q.push_back(x);
        end
    endtask

    // Decide what the next cycle looks like, given inputs seen at the coming edge.
    task automatic model_step(input logic s, input logic d);
        if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (cur.ena) begin
            cur = wait_rec(mode, blk);
        end else begin
            case (mode)
                M_IDLE, M_DONE: if (s) begin
                    blk = 0;
                    push_phase(K_INIT, 0);
                    mode = M_WAIT_AD;
                end
                M_WAIT_AD: if (d) begin
                    push_phase(K_AD, blk);
                    mode = M_WAIT_PT;
                end
                default: if (d) begin
                    if (blk < NB - 1) begin
                        push_phase(K_PT, blk);
                        blk++;
                    end else begin
                        push_phase(K_FIN, blk);
                        mode = M_DONE;
                    end
                end
            endcase
            cur = (q.size() != 0) ? q.pop_front() : wait_rec(mode, blk);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_IDLE;
        blk  = 0;
        cur  = wait_rec(M_IDLE, 0);
    endtask

    task automatic tick(input logic s, input logic d);
        io.start_i      = s;
        io.data_valid_i = d;
        model_step(s, d);
        @(posedge clock_i);
        #1;
        if (io.tag_valid_o) n_tags++;
        chk("cycle", pack_dut(), {14'd0, cur});
    endtask

    initial begin
        io.start_i      = 1'b0;
        io.data_valid_i = 1'b0;
        model_reset();
        #3;
        chk("reset", pack_dut(), {14'd0, cur});
        @(negedge clock_i);
        resetb_i = 1'b1;

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        chk("init_r5", {28'd0, io.round_o}, 32'd5);

        #2;
        resetb_i = 1'b0;
        model_reset();
        #1;
        chk("reset_mid", pack_dut(), {14'd0, cur});
        @(negedge clock_i);
        resetb_i = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);

        // First message directed: AD held off for 3 cycles, then valid answered at once.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 900; i++)
            tick(($urandom_range(3) == 0), ($urandom_range(1) == 1));

        chk("tags_seen", {31'd0, (n_tags >= 3)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
